// File: rtl/data_sram_responder.sv
// data_sram_responder: byte-lane-writable word SRAM with one-cycle read-first latency, post-reset init sweep and range flag
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   data_ram_enabled             : access request (read always, write when any strobe set)
//   data_ram_write_enabled[3:0]  : byte-lane write strobes
//   data_ram_address[31:0]       : byte address, word index in [ADDRESS_WIDTH+1:2]
//   data_ram_write_data[31:0]    : lane-aligned write data
//   data_ram_read_data[31:0]     : read data, valid the cycle after an enabled request
//   init_busy                    : high while the init sweep runs
//   range_error                  : one-cycle pulse aligned with read data for out-of-range requests
module data_sram_responder #(
  parameter int          ADDRESS_WIDTH = 16,
  parameter logic [31:0] INIT_VALUE    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_ram_enabled,
  input  logic [3:0]  data_ram_write_enabled,
  input  logic [31:0] data_ram_address,
  input  logic [31:0] data_ram_write_data,
  output logic [31:0] data_ram_read_data,
  output logic        init_busy,
  output logic        range_error
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  typedef enum logic {INIT, READY} state_t;
  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] count;
  logic [31:0]              mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] idx, waddr;
  logic                     in_range, unused_low;
  logic [3:0]               we;
  logic [31:0]              wdata;
  assign idx        = data_ram_address[ADDRESS_WIDTH+1:2];
  assign in_range   = data_ram_address[31:ADDRESS_WIDTH+2] == '0;
  assign unused_low = ^data_ram_address[1:0];
  assign init_busy  = state == INIT;
  // the sweep borrows the single write port; reset suppresses all writes
  assign we    = reset ? 4'h0 : init_busy ? 4'hF : (data_ram_enabled && in_range) ? data_ram_write_enabled : 4'h0;
  assign waddr = init_busy ? count : idx;
  assign wdata = init_busy ? INIT_VALUE : data_ram_write_data;
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= INIT;
      count              <= '0;
      data_ram_read_data <= '0;
      range_error        <= 1'b0;
    end else if (state == INIT) begin
      count       <= count + 1'b1;
      range_error <= 1'b0;
      if (count == ADDRESS_WIDTH'(DEPTH - 1)) state <= READY;
    end else begin
      range_error <= data_ram_enabled && !in_range;
      if (data_ram_enabled) data_ram_read_data <= in_range ? mem[idx] : 32'h0;
    end
  end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Responder end of the data SRAM interface driven by the execute stage: a word-organised, byte-write-enabled synchronous memory with one-cycle read latency. It serves loads and stores, including partial-lane stores (SB/SH/SWL/SWR strobes), and flags out-of-range accesses. After reset, an init sweep fills every word with a known value, so simulation and FPGA runs start from deterministic memory. It sits beside the CPU core, taking the core's data_ram_* outputs and returning read data to the memory-access stage.

Parameters:
ADDRESS_WIDTH, 16, word-index bits; depth = 2**ADDRESS_WIDTH words (byte span = 2**(ADDRESS_WIDTH+2))
INIT_VALUE, 32'h0000_0000, value written to every word during the post-reset sweep

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
data_ram_enabled  input  1  access request this cycle (read always; write when any strobe set)
data_ram_write_enabled  input  4  byte-lane write strobes, bit i -> bits [8i+7:8i]
data_ram_address  input  32  byte address; word index = address[ADDRESS_WIDTH+1:2]
data_ram_write_data  input  32  write data, already lane-replicated/shifted by the initiator
data_ram_read_data  output  32  read data, valid the cycle after an enabled request
init_busy  output  1  high while the post-reset sweep runs; requests ignored
range_error  output  1  one-cycle pulse, aligned with read data, for an out-of-range request

Behaviour:
- Reset (sync, active-high), applied at an edge:
  - data_ram_read_data=0, range_error=0, init_busy=1.
  - State=INIT, sweep counter=0.
- INIT:
  - Each cycle writes INIT_VALUE to word[counter] and increments the counter.
  - After word DEPTH-1 is written, the next edge enters READY; init_busy is high for exactly DEPTH cycles.
  - All requests are ignored: no writes, read_data stays 0, range_error stays 0.
  - Reset asserted mid-sweep restarts the sweep at word 0.
- READY, request accepted when data_ram_enabled=1:
  - In range: address[31:ADDRESS_WIDTH+2]==0.
  - Write: for each strobe bit i set, word[idx][8i+7:8i] <= write_data[8i+7:8i]. Unset lanes are unchanged. Strobes 0 means pure read.
  - Read: the next cycle, read_data = word[idx] as it was before this edge (read-first). A same-cycle write to the same word returns old data; the new data is visible on the following read.
  - address[1:0] is ignored by the memory. Lane selection comes only from the strobes.
  - Out of range: writes are dropped. The next cycle, read_data=0 and range_error=1 for one cycle. Memory is unchanged.
- data_ram_enabled=0:
  - No write, even with strobes set.
  - read_data holds its previous value; range_error=0 next cycle.
- Back-to-back requests are accepted every cycle. There is no stall or ready signal, so throughput is one access per cycle.
- Latency: request at edge N -> data/range_error valid after edge N+1, held until the next enabled request.
- Implementation: single-port array inferable as block RAM (one write port with byte enables, one synchronous read). The INIT sweep shares the write port through a mux. No asynchronous logic.

Test Plan (ADDRESS_WIDTH=4, depth 16):
- Reset 1 cycle then release -> init_busy=1 for exactly 16 cycles then 0. A read issued during INIT to 0x8 with strobes 4'hF, data 0xDEADBEEF leaves word 2 at INIT_VALUE; a later read of 0x8 returns 0x00000000.
- After init: write 0x11223344 to 0x4 (strobes F), then SB-style write strobes 4'b0100, data 0xAAAAAAAA to 0x6 -> read 0x4 returns 0x11AA3344 one cycle after the request.
- Same-cycle read/write: word 3 holds 0x12345678; request 0xC with strobes F, data 0xCAFEF00D -> read_data=0x12345678; the next read of 0xC gives 0xCAFEF00D.
- Out of range: request 0x40 with strobes F, data 0xFFFFFFFF -> range_error pulses 1 cycle, read_data=0. A subsequent read of 0x0 shows that word 0 is unchanged.
- Enable low with strobes F to 0x0 -> no write, read_data holds its last value, range_error=0.
- Reset asserted at sweep cycle 7 after memory was written with 0x55555555 -> sweep restarts and init_busy stays high 16 more cycles. Then all 16 words read INIT_VALUE, back-to-back, one per cycle.
